// File: rtl/fft_pkg.sv
// Shared FFT parameters and the streamer state type.
package fft_pkg;

   localparam int unsigned FFT_N         = 8;
   localparam int unsigned FFT_DATA_W    = 21;
   localparam int unsigned FFT_FRAC_BITS = 15;
   localparam int unsigned FFT_LATENCY   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STREAM = 2'd2
   } fft_state_e;

endpackage

// File: rtl/fft_latency_counter.sv
// Down-counter that tracks the FFT pipeline delay; flags zero when data is due.
module fft_latency_counter
   import fft_pkg::*;
#(
   parameter int unsigned LATENCY = FFT_LATENCY
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero_c
);

   localparam int unsigned CNT_W = $clog2(LATENCY + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CNT_W'(LATENCY - 1);
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/fft_bin_streamer.sv
// Captures the parallel FFT result after a fixed latency and streams it
// out one bin per valid/ready beat.
module fft_bin_streamer
   import fft_pkg::*;
#(
   parameter int unsigned N             = FFT_N,
   parameter int unsigned DATA_W        = FFT_DATA_W,
   parameter int unsigned FFT_LATENCY   = fft_pkg::FFT_LATENCY,
   parameter bit          HALF_SPECTRUM = 1'b0,
   parameter int unsigned IDX_W         = $clog2(N)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fft_valid_i,
   input  logic signed [DATA_W-1:0] y_re_i [0:N-1],
   input  logic signed [DATA_W-1:0] y_im_i [0:N-1],
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic signed [DATA_W-1:0] m_re_o,
   output logic signed [DATA_W-1:0] m_im_o,
   output logic [IDX_W-1:0]         m_idx_o,
   output logic                     m_last_o,
   output logic                     busy_o,
   output logic                     overrun_o
);

   localparam logic [IDX_W-1:0] LAST = HALF_SPECTRUM ? IDX_W'(N / 2) : IDX_W'(N - 1);

   fft_state_e state_q, state_n;

   logic [IDX_W-1:0]         idx_q, idx_n, idx_inc;
   logic                     valid_q, valid_n;
   logic                     last_q, last_n;
   logic                     busy_q, busy_n;
   logic                     overrun_q, overrun_n;
   logic signed [DATA_W-1:0] re_q, re_n, im_q, im_n;
   logic                     load, dec, capture, zero_c;
   logic                     hs, last_hs;

   logic signed [DATA_W-1:0] buf_re [0:N-1];
   logic signed [DATA_W-1:0] buf_im [0:N-1];

   fft_latency_counter #(.LATENCY(FFT_LATENCY)) u_cnt (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (load),
      .dec    (dec),
      .zero_c (zero_c)
   );

   assign idx_inc = idx_q + IDX_W'(1);
   assign hs      = valid_q && m_ready_i;
   assign last_hs = hs && last_q;

   // Next-state and next-output logic; output data is pre-fetched so every port is a flop.
   always_comb begin
      state_n   = state_q;
      idx_n     = idx_q;
      valid_n   = valid_q;
      last_n    = last_q;
      re_n      = re_q;
      im_n      = im_q;
      overrun_n = 1'b0;
      load      = 1'b0;
      dec       = 1'b0;
      capture   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fft_valid_i) begin
               state_n = ST_WAIT;
               load    = 1'b1;
            end
         end
         ST_WAIT: begin
            overrun_n = fft_valid_i;
            if (zero_c) begin
               capture = 1'b1;
               state_n = ST_STREAM;
               idx_n   = '0;
               valid_n = 1'b1;
               last_n  = 1'b0;
               re_n    = y_re_i[0];
               im_n    = y_im_i[0];
            end else begin
               dec = 1'b1;
            end
         end
         ST_STREAM: begin
            overrun_n = fft_valid_i && !last_hs;
            if (last_hs) begin
               valid_n = 1'b0;
               last_n  = 1'b0;
               idx_n   = '0;
               re_n    = '0;
               im_n    = '0;
               if (fft_valid_i) begin
                  state_n = ST_WAIT;
                  load    = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end else if (hs) begin
               idx_n  = idx_inc;
               re_n   = buf_re[idx_inc];
               im_n   = buf_im[idx_inc];
               last_n = (idx_inc == LAST);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         re_q      <= '0;
         im_q      <= '0;
      end else begin
         state_q   <= state_n;
         idx_q     <= idx_n;
         valid_q   <= valid_n;
         last_q    <= last_n;
         busy_q    <= busy_n;
         overrun_q <= overrun_n;
         re_q      <= re_n;
         im_q      <= im_n;
      end
   end

   // Frame buffer needs no reset; it is only read after a capture.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         for (int unsigned k = 0; k < N; k++) begin
            buf_re[k] <= y_re_i[k];
            buf_im[k] <= y_im_i[k];
         end
      end
   end

   assign m_valid_o = valid_q;
   assign m_re_o    = re_q;
   assign m_im_o    = im_q;
   assign m_idx_o   = idx_q;
   assign m_last_o  = last_q;
   assign busy_o    = busy_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed self-checking bench for fft_bin_streamer (full and half spectrum).
module tb_fft_bin_streamer;

   localparam int unsigned N   = 8;
   localparam int unsigned DW  = 21;
   localparam int unsigned LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fft_valid = 1'b0;
   logic ready = 1'b0;
   logic signed [DW-1:0] y_re [0:N-1];
   logic signed [DW-1:0] y_im [0:N-1];

   logic                 m_valid, m_last, busy, overrun;
   logic signed [DW-1:0] m_re, m_im;
   logic [2:0]           m_idx;
   logic                 h_valid, h_last, h_busy, h_overrun;
   logic signed [DW-1:0] h_re, h_im;
   logic [2:0]           h_idx;

   int n_assert = 0;
   int n_fail   = 0;

   fft_bin_streamer #(.N(N), .DATA_W(DW), .FFT_LATENCY(LAT), .HALF_SPECTRUM(1'b0)) u_full (
      .clk_i(clk), .rst_i(rst), .fft_valid_i(fft_valid), .y_re_i(y_re), .y_im_i(y_im),
      .m_valid_o(m_valid), .m_ready_i(ready), .m_re_o(m_re), .m_im_o(m_im),
      .m_idx_o(m_idx), .m_last_o(m_last), .busy_o(busy), .overrun_o(overrun)
   );

   fft_bin_streamer #(.N(N), .DATA_W(DW), .FFT_LATENCY(LAT), .HALF_SPECTRUM(1'b1)) u_half (
      .clk_i(clk), .rst_i(rst), .fft_valid_i(fft_valid), .y_re_i(y_re), .y_im_i(y_im),
      .m_valid_o(h_valid), .m_ready_i(ready), .m_re_o(h_re), .m_im_o(h_im),
      .m_idx_o(h_idx), .m_last_o(h_last), .busy_o(h_busy), .overrun_o(h_overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_bins(input int base, input int step, input bit neg_im);
      for (int k = 0; k < N; k++) begin
         y_re[k] = DW'(base + step * k);
         y_im[k] = neg_im ? -DW'(base + step * k) : '0;
      end
   endtask

   task automatic strobe();
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
   endtask

   // Counts edges until the full instance presents a beat; bounded.
   task automatic wait_valid(output int cnt);
      cnt = 0;
      while (!m_valid && cnt < 40) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      int cnt, exp_k, beats, n_ov;
      bit pat [0:3];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      set_bins(0, 0, 1'b0);

      // Reset state
      tick(); tick();
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", m_idx, 0);
      chk("rst_re", m_re, 0);
      rst = 1'b0;
      tick();

      // DC frame
      set_bins(0, 0, 1'b0);
      y_re[0] = DW'(131072);
      ready = 1'b1;
      strobe();
      chk("dc_busy", busy, 1);
      chk("dc_valid_early", m_valid, 0);
      wait_valid(cnt);
      chk("dc_latency", cnt, LAT);
      for (int k = 0; k < N; k++) begin
         chk("dc_valid", m_valid, 1);
         chk("dc_idx", m_idx, k);
         chk("dc_re", m_re, (k == 0) ? 131072 : 0);
         chk("dc_im", m_im, 0);
         chk("dc_last", m_last, (k == N - 1) ? 1 : 0);
         tick();
      end
      chk("dc_valid_end", m_valid, 0);
      chk("dc_busy_end", busy, 0);
      repeat (4) tick();

      // Back-pressure
      set_bins(1, 1, 1'b1);
      ready = 1'b0;
      strobe();
      wait_valid(cnt);
      chk("bp_latency", cnt, LAT);
      exp_k = 0;
      for (int c = 0; c < 100; c++) begin
         if (exp_k == N) break;
         ready = pat[c % 4];
         if (m_valid) begin
            chk("bp_idx", m_idx, exp_k);
            chk("bp_re", m_re, exp_k + 1);
            chk("bp_im", m_im, -(exp_k + 1));
            chk("bp_last", m_last, (exp_k == N - 1) ? 1 : 0);
            if (ready) exp_k++;
         end
         tick();
      end
      chk("bp_beats", exp_k, N);
      ready = 1'b1;
      chk("bp_valid_end", m_valid, 0);
      repeat (4) tick();

      // Overrun: second strobe two cycles after the first
      set_bins(10, 1, 1'b0);
      strobe();
      tick();
      strobe();
      n_ov = 0; beats = 0;
      for (int c = 0; c < 30; c++) begin
         if (overrun) n_ov++;
         if (m_valid && ready) begin
            chk("ov_idx", m_idx, beats);
            beats++;
         end
         tick();
      end
      chk("ov_pulses", n_ov, 1);
      chk("ov_beats", beats, N);
      chk("ov_busy_end", busy, 0);

      // Back-to-back: strobe on the final handshake
      set_bins(100, 1, 1'b0);
      strobe();
      wait_valid(cnt);
      chk("b2b_latency1", cnt, LAT);
      while (m_valid && m_idx != 3'd7) tick();
      chk("b2b_at_last", m_last, 1);
      set_bins(200, 1, 1'b0);
      strobe();
      n_ov = 0;
      cnt = 0;
      while (!m_valid && cnt < 40) begin
         if (overrun) n_ov++;
         tick();
         cnt++;
      end
      chk("b2b_latency2", cnt, LAT);
      chk("b2b_overrun", n_ov, 0);
      chk("b2b_idx0", m_idx, 0);
      chk("b2b_re0", m_re, 200);
      repeat (N) tick();
      chk("b2b_done", m_valid, 0);
      repeat (4) tick();

      // Half spectrum instance
      set_bins(0, 3, 1'b1);
      strobe();
      cnt = 0;
      while (!h_valid && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("hs_latency", cnt, LAT);
      for (int k = 0; k <= N / 2; k++) begin
         chk("hs_valid", h_valid, 1);
         chk("hs_idx", h_idx, k);
         chk("hs_re", h_re, 3 * k);
         chk("hs_last", h_last, (k == N / 2) ? 1 : 0);
         tick();
      end
      chk("hs_valid_end", h_valid, 0);
      repeat (8) tick();

      // Asynchronous reset mid-stream at idx 3
      set_bins(50, 1, 1'b0);
      strobe();
      wait_valid(cnt);
      while (m_valid && m_idx != 3'd3) tick();
      ready = 1'b0;
      chk("mr_idx3", m_idx, 3);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid", m_valid, 0);
      chk("mr_idx", m_idx, 0);
      chk("mr_re", m_re, 0);
      chk("mr_busy", busy, 0);
      chk("mr_last", m_last, 0);
      tick();
      rst = 1'b0;
      ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 15; c++) begin
         if (m_valid) beats++;
         tick();
      end
      chk("mr_no_beats", beats, 0);
      chk("mr_busy_after", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_bin_streamer.md
# fft_bin_streamer

Output-side companion to `top_fft`: captures the N parallel complex bins that `top_fft` presents on `y_re_o`/`y_im_o` a fixed number of cycles after its `valid_i` pulse, then streams them out one bin per beat on a valid/ready interface. It sits directly downstream of `top_fft` and shares its `valid_i` strobe. It converts the FFT's parallel, handshake-free result into a back-pressurable serial stream for magnitude, logging or UART blocks.

## Interface
- `N`, 8: FFT size (power of two, ≥2); must match `top_fft`.
- `DATA_W`, 21: signed bin width (Q.15 fraction, matches `top_fft` output).
- `FFT_LATENCY`, 4: rising edges from the `valid_i` sample to stable `top_fft` outputs; ≥1.
- `HALF_SPECTRUM`, 0: if 1, stream bins 0..N/2 only (real-input symmetry); else 0..N-1.
- `IDX_W`, `$clog2(N)`: derived; do not override.

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `fft_valid_i`  in  1  same one-cycle strobe driven to `top_fft.valid_i`.
- `y_re_i[0:N-1]`  in  DATA_W signed  `top_fft` real outputs.
- `y_im_i[0:N-1]`  in  DATA_W signed  `top_fft` imaginary outputs.
- `m_valid_o`  out  1  bin beat valid.
- `m_ready_i`  in  1  downstream ready.
- `m_re_o`  out  DATA_W signed  bin real part.
- `m_im_o`  out  DATA_W signed  bin imaginary part.
- `m_idx_o`  out  IDX_W  bin index.
- `m_last_o`  out  1  final bin of frame.
- `busy_o`  out  1  state ≠ IDLE.
- `overrun_o`  out  1  one-cycle pulse: strobe dropped.

## Operation
- FSM states IDLE, WAIT, STREAM.
- IDLE: `fft_valid_i`=1 → WAIT, latency counter loaded with FFT_LATENCY-1.
- WAIT: counter decrements each cycle. At 0, the edge captures all `y_re_i`/`y_im_i` into an internal N-entry buffer and enters STREAM with idx=0.
- STREAM: `m_valid_o`=1, and outputs are driven from `buffer[idx]`. On `m_valid_o && m_ready_i`, idx increments. On the beat where idx = LAST (N-1, or N/2 if HALF_SPECTRUM), `m_last_o`=1. That handshake returns to IDLE.
- Simultaneous last-beat handshake and `fft_valid_i`=1: strobe accepted, next state WAIT (counter reloaded). No overrun.
- `fft_valid_i`=1 in WAIT, or in STREAM without a last-beat handshake: strobe ignored, frame in progress unaffected, `overrun_o` pulses the next cycle.
- Outputs are stable while `m_valid_o`=1 and `m_ready_i`=0 (AXI-stream rule). `m_valid_o` never deasserts before its handshake.
- Captured data is passed bit-exact; no scaling or rounding.
- Reset, including mid-frame: state IDLE, idx 0, counter 0, `m_valid_o`/`m_last_o`/`busy_o`/`overrun_o` 0, `m_re_o`/`m_im_o`/`m_idx_o` 0. Buffer contents are don't-care.

## Timing
- Strobe sampled at edge E0 → capture at edge E0+FFT_LATENCY → `m_valid_o` high in the cycle following that edge.
- With `m_ready_i` held 1, one bin per cycle. The frame occupies LAST+1 consecutive cycles.
- Minimum strobe spacing for lossless operation: FFT_LATENCY + LAST + 1 cycles (back-to-back allowed via the simultaneous rule).
- All outputs registered; no combinational path from `m_ready_i` to `m_valid_o`.

## Structure
- Shared package `fft_pkg`: `FFT_N`, `FFT_DATA_W`, `FFT_FRAC_BITS`=15, `FFT_LATENCY`, and a state enum type, reused by `top_fft` and this block.
- One sub-module is natural: `fft_latency_counter` (load/decrement/zero flag). The buffer and FSM stay inline.

## Test plan
- DC frame: bench drives bin0 = (131072, 0), other bins = 0, strobe, `m_ready_i`=1 → `m_valid_o` rises at E0+FFT_LATENCY+1. Beats idx 0..7 in consecutive cycles with re = 131072, 0,…,0, `m_last_o` only on idx 7.
- Back-pressure: `m_ready_i` toggled 1,0,0,1,… with bins re[k]=k+1, im[k]=-(k+1) → every idx 0..7 appears exactly once in order. Outputs hold constant during stalls.
- Overrun: second strobe 2 cycles after the first → `overrun_o` pulses once, and exactly 8 beats from the first frame are emitted. Then `busy_o`=0.
- Back-to-back: strobe coincident with the idx-7 handshake → no overrun. The second frame's idx 0 appears FFT_LATENCY+1 cycles later with the new data.
- HALF_SPECTRUM=1: 5 beats idx 0..4, with `m_last_o` on idx 4.
- Reset asserted mid-STREAM at idx 3 → all outputs 0 immediately (async). After release, no beats appear until a new strobe.
